// File: rtl/add64_pipe_stage.sv
// Two-stage valid/ready 64-bit add/sub pipeline: S1 operand register -> cond_sum64 -> S2 result register.
// Adds ADD/SUB/ADC/SBB operand conditioning and an architectural carry register loaded as each op enters S2.

module cond_sum64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  logic [16:0] blk_c0 [4];
  logic [16:0] blk_c1 [4];
  logic [4:0]  c;

  // Each 16-bit block precomputes both carry-in outcomes; the incoming carry picks one.
  always_comb begin
    c    = '0;
    c[0] = cin;
    sum  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      blk_c0[i]          = {1'b0, a[i*16 +: 16]} + {1'b0, b[i*16 +: 16]};
      blk_c1[i]          = {1'b0, a[i*16 +: 16]} + {1'b0, b[i*16 +: 16]} + 17'd1;
      sum[i*16 +: 16]    = c[i] ? blk_c1[i][15:0] : blk_c0[i][15:0];
      c[i+1]             = c[i] ? blk_c1[i][16]   : blk_c0[i][16];
    end
    cout = c[4];
  end
endmodule

module add64_pipe_stage #(
  parameter logic        CF_RST_VAL = 1'b0,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic             out_cf,
  output logic             out_of,
  output logic             out_zf,
  output logic             out_sf,
  output logic [TAG_W-1:0] out_tag,
  output logic             cf_q
);
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [63:0]      s1_a_q, s1_a_d;
  logic [63:0]      s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [63:0]      s2_sum_q, s2_sum_d;
  logic             s2_cf_q, s2_cf_d;
  logic             s2_of_q, s2_of_d;
  logic             s2_zf_q, s2_zf_d;
  logic             s2_sf_q, s2_sf_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             cf_d;

  logic        s2_free, s1_adv, accept;
  logic [63:0] bx, sum;
  logic        cin, cout, cf_flag, of_flag;

  always_comb begin
    s2_free  = !s2_valid_q | out_ready;
    s1_adv   = s1_valid_q & s2_free & !flush;
    in_ready = !flush & (!s1_valid_q | s2_free);
    accept   = in_valid & in_ready;
  end

  // SUB/SBB invert B; SBB carries in the complement of the stored borrow.
  always_comb begin
    bx  = s1_op_q[0] ? ~s1_b_q : s1_b_q;
    cin = 1'b0;
    unique case (s1_op_q)
      OP_ADD: cin = 1'b0;
      OP_SUB: cin = 1'b1;
      OP_ADC: cin = cf_q;
      OP_SBB: cin = ~cf_q;
      default: cin = 1'b0;
    endcase
  end

  cond_sum64 u_sum (
    .a    (s1_a_q),
    .b    (bx),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    cf_flag = s1_op_q[0] ? ~cout : cout;
    of_flag = (s1_a_q[63] == bx[63]) & (sum[63] != s1_a_q[63]);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_cf_d    = s2_cf_q;
    s2_of_d    = s2_of_q;
    s2_zf_d    = s2_zf_q;
    s2_sf_d    = s2_sf_q;
    s2_tag_d   = s2_tag_q;
    cf_d       = cf_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid_d = 1'b1;
        s2_sum_d   = sum;
        s2_cf_d    = cf_flag;
        s2_of_d    = of_flag;
        s2_zf_d    = ~|sum;
        s2_sf_d    = sum[63];
        s2_tag_d   = s1_tag_q;
        cf_d       = cf_flag;
      end else if (out_ready) begin
        s2_valid_d = 1'b0;
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_op_d    = op_e'(in_op);
        s1_a_d     = in_a;
        s1_b_d     = in_b;
        s1_tag_d   = in_tag;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_cf_q    <= 1'b0;
      s2_of_q    <= 1'b0;
      s2_zf_q    <= 1'b0;
      s2_sf_q    <= 1'b0;
      s2_tag_q   <= '0;
      cf_q       <= CF_RST_VAL;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_cf_q    <= s2_cf_d;
      s2_of_q    <= s2_of_d;
      s2_zf_q    <= s2_zf_d;
      s2_sf_q    <= s2_sf_d;
      s2_tag_q   <= s2_tag_d;
      cf_q       <= cf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_cf    = s2_cf_q;
  assign out_of    = s2_of_q;
  assign out_zf    = s2_zf_q;
  assign out_sf    = s2_sf_q;
  assign out_tag   = s2_tag_q;
endmodule

// File: tb/tb_add64_pipe_stage.sv
// Directed bench for add64_pipe_stage: vector table for arithmetic/flags, hand sequences for
// back-to-back carry chain, backpressure, flush and mid-operation reset.

module tb_add64_pipe_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a, in_b, out_sum;
  logic [3:0]  in_tag, out_tag;
  logic        out_cf, out_of, out_zf, out_sf, cf_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add64_pipe_stage #(.CF_RST_VAL(1'b1), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cf(out_cf), .out_of(out_of), .out_zf(out_zf), .out_sf(out_sf),
    .out_tag(out_tag), .cf_q(cf_q)
  );

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic        cf;
    logic        of;
    logic        zf;
    logic        sf;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  logic [63:0] held_sum;

  initial begin
    // op: 00 ADD, 01 SUB, 10 ADC, 11 SBB; carry state flows vector to vector.
    vecs[0]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{2'b10, 64'd0, 64'd0, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{2'b11, 64'd10, 64'd3, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 64'd5, 64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{2'b01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b11, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211,
                 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, '0, '0, 4'h0);
    tick(); tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_tag", {60'd0, out_tag}, 64'd0);
    chk("rst_cf_q", {63'd0, cf_q}, 64'd1);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single-beat vectors: accept, one bubble edge, then result visible.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
      tick();
      drive(1'b0, 2'b00, '0, '0, 4'h0);
      chk($sformatf("v%0d_lat", i), {63'd0, out_valid}, 64'd0);
      tick();
      chk($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("v%0d_sum", i), out_sum, vecs[i].sum);
      chk($sformatf("v%0d_flags", i), {60'd0, out_cf, out_of, out_zf, out_sf},
          {60'd0, vecs[i].cf, vecs[i].of, vecs[i].zf, vecs[i].sf});
      chk($sformatf("v%0d_tag", i), {60'd0, out_tag}, 64'(i));
      chk($sformatf("v%0d_cf_q", i), {63'd0, cf_q}, {63'd0, vecs[i].cf});
      tick();
    end

    // 128-bit chain issued back to back.
    drive(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'hA);
    tick();
    drive(1'b1, 2'b10, 64'd0, 64'd0, 4'hB);
    chk("chain_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 2'b00, '0, '0, 4'h0);
    chk("chain_lo_sum", out_sum, 64'd0);
    chk("chain_lo_cf", {60'd0, out_tag, out_valid, out_cf, out_zf}, {60'd0, 4'hA, 1'b1, 1'b1, 1'b1});
    tick();
    chk("chain_hi_sum", out_sum, 64'd1);
    chk("chain_hi_tag", {60'd0, out_tag, out_valid, out_cf, cf_q}, {60'd0, 4'hB, 1'b1, 1'b0, 1'b0});
    tick();
    chk("chain_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: three beats offered, two held.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 64'd1, 64'd0, 4'h1);
    tick();
    drive(1'b1, 2'b00, 64'd2, 64'd0, 4'h2);
    tick();
    drive(1'b1, 2'b00, 64'd3, 64'd0, 4'h3);
    held_sum = out_sum;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
      chk($sformatf("bp%0d_out", k), {59'd0, out_valid, out_tag}, {59'd0, 1'b1, 4'h1});
      chk($sformatf("bp%0d_sum", k), out_sum, 64'd1);
      chk($sformatf("bp%0d_stable", k), out_sum, held_sum);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 2'b00, '0, '0, 4'h0);
    chk("bp_tag2", {59'd0, out_valid, out_tag}, {59'd0, 1'b1, 4'h2});
    chk("bp_sum2", out_sum, 64'd2);
    tick();
    chk("bp_tag3", {59'd0, out_valid, out_tag}, {59'd0, 1'b1, 4'h3});
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Flush with both stages full; S1 holds an op whose CF differs from cf_q.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 64'd1, 64'd1, 4'h4);
    tick();
    drive(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h5);
    tick();
    chk("fl_full", {62'd0, out_valid, cf_q}, {62'd0, 1'b1, 1'b0});
    drive(1'b1, 2'b00, 64'd7, 64'd7, 4'h6);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 4'h0);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_cf_q", {63'd0, cf_q}, 64'd0);
    tick();
    chk("fl_no_accept", {63'd0, out_valid}, 64'd0);
    tick();
    chk("fl_no_accept2", {63'd0, out_valid}, 64'd0);

    // Reset with both stages full and cf_q opposite to its reset value.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 64'd8, 64'd0, 4'h7);
    tick();
    drive(1'b1, 2'b00, 64'd9, 64'd0, 4'h8);
    tick();
    drive(1'b0, 2'b00, '0, '0, 4'h0);
    chk("rm_full", {62'd0, out_valid, cf_q}, {62'd0, 1'b1, 1'b0});
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rm_cf_q", {63'd0, cf_q}, 64'd1);
    chk("rm_out_sum", out_sum, 64'd0);
    tick();
    chk("rm_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rm_idle", {63'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
